sys_cmd_gen: RTL and testbench

Host-side command frame generator: the initiator end of the system-control byte protocol. It accepts one command at a time from a local requester, serializes it into the framed byte stream (0xAA write, 0xBB read, 0xCC ALU-with-operands, 0xDD ALU-no-operands) toward the UART TX path, then collects the 1- or 2-byte response from the UART RX path. Used as the test/host model and in loopback configurations driving the system controller.

---
 rtl/sys_cmd_gen_if.sv | 33 +++
 rtl/sys_cmd_gen.sv | 158 +++++++++++++++
 tb/tb_sys_cmd_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_gen_if.sv
// Bundle of command request, UART byte-stream and response signals of the host command generator.
// The generator uses the master modport; the requester/UART environment uses the slave modport.
interface sys_cmd_gen_if;
   logic        cmdVld;
   logic        cmdRdy;
   logic [1:0]  cmdType;
   logic [3:0]  cmdAddr;
   logic [7:0]  cmdData;
   logic [7:0]  cmdOpa;
   logic [7:0]  cmdOpb;
   logic [3:0]  cmdFun;
   logic [7:0]  txPData;
   logic        txDVld;
   logic        txRdy;
   logic [7:0]  rxPData;
   logic        rxDVld;
   logic [15:0] rspData;
   logic        rspVld;
   logic        rspTimeout;
   logic        busy;

   modport master (
      input  cmdVld, cmdType, cmdAddr, cmdData, cmdOpa, cmdOpb, cmdFun,
      input  txRdy, rxPData, rxDVld,
      output cmdRdy, txPData, txDVld, rspData, rspVld, rspTimeout, busy
   );

   modport slave (
      output cmdVld, cmdType, cmdAddr, cmdData, cmdOpa, cmdOpb, cmdFun,
      output txRdy, rxPData, rxDVld,
      input  cmdRdy, txPData, txDVld, rspData, rspVld, rspTimeout, busy
   );
endinterface

// File: rtl/sys_cmd_gen.sv
// Host-side command frame generator: serializes one command into the framed byte stream,
// then collects its 1- or 2-byte response with a restartable timeout.
module sys_cmd_gen #(
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   sys_cmd_gen_if.master bus
);
   typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      r_state;
   logic [1:0]  r_idx;
   logic [1:0]  r_type;
   logic [3:0]  r_addr;
   logic [3:0]  r_fun;
   logic [7:0]  r_data;
   logic [7:0]  r_opa;
   logic [7:0]  r_opb;
   logic [7:0]  r_b0;
   logic        r_haveB0;
   logic [15:0] r_cnt;
   logic [7:0]  r_txData;
   logic        r_txVld;
   logic [15:0] r_rspData;
   logic        r_rspVld;
   logic        r_rspTo;

   logic [7:0]  w_header;
   logic [1:0]  w_lastIdx;
   logic [1:0]  w_nextIdx;
   logic [7:0]  w_nextByte;

   assign w_nextIdx = r_idx + 2'd1;

   always_comb begin
      w_header   = 8'hAA;
      w_lastIdx  = 2'd1;
      w_nextByte = {4'h0, r_fun};
      case (bus.cmdType)
         2'd0:    w_header = 8'hAA;
         2'd1:    w_header = 8'hBB;
         2'd2:    w_header = 8'hCC;
         default: w_header = 8'hDD;
      endcase
      // Payload bytes come from the latched fields; index 0 (header) is loaded at accept.
      case (r_type)
         2'd0: begin
            w_lastIdx  = 2'd2;
            w_nextByte = (w_nextIdx == 2'd1) ? {4'h0, r_addr} : r_data;
         end
         2'd1: begin
            w_lastIdx  = 2'd1;
            w_nextByte = {4'h0, r_addr};
         end
         2'd2: begin
            w_lastIdx = 2'd3;
            case (w_nextIdx)
               2'd1:    w_nextByte = r_opa;
               2'd2:    w_nextByte = r_opb;
               default: w_nextByte = {4'h0, r_fun};
            endcase
         end
         default: begin
            w_lastIdx  = 2'd1;
            w_nextByte = {4'h0, r_fun};
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_idx     <= 2'd0;
         r_type    <= 2'd0;
         r_addr    <= 4'h0;
         r_fun     <= 4'h0;
         r_data    <= 8'h00;
         r_opa     <= 8'h00;
         r_opb     <= 8'h00;
         r_b0      <= 8'h00;
         r_haveB0  <= 1'b0;
         r_cnt     <= 16'h0000;
         r_txData  <= 8'h00;
         r_txVld   <= 1'b0;
         r_rspData <= 16'h0000;
         r_rspVld  <= 1'b0;
         r_rspTo   <= 1'b0;
      end else begin
         r_rspVld <= 1'b0;
         r_rspTo  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.cmdVld) begin
                  r_type   <= bus.cmdType;
                  r_addr   <= bus.cmdAddr;
                  r_data   <= bus.cmdData;
                  r_opa    <= bus.cmdOpa;
                  r_opb    <= bus.cmdOpb;
                  r_fun    <= bus.cmdFun;
                  r_txData <= w_header;
                  r_txVld  <= 1'b1;
                  r_idx    <= 2'd0;
                  r_state  <= SEND;
               end
            end
            SEND: begin
               if (r_txVld && bus.txRdy) begin
                  if (r_idx == w_lastIdx) begin
                     r_txVld  <= 1'b0;
                     r_idx    <= 2'd0;
                     r_cnt    <= 16'h0000;
                     r_haveB0 <= 1'b0;
                     r_state  <= (r_type == 2'd0) ? IDLE : WAIT_RSP;
                  end else begin
                     r_idx    <= w_nextIdx;
                     r_txData <= w_nextByte;
                  end
               end
            end
            WAIT_RSP: begin
               // A byte arriving on the expiry cycle takes priority over the timeout.
               if (bus.rxDVld) begin
                  r_cnt <= 16'h0000;
                  if (r_type == 2'd1) begin
                     r_rspData <= {8'h00, bus.rxPData};
                     r_rspVld  <= 1'b1;
                     r_state   <= IDLE;
                  end else if (!r_haveB0) begin
                     r_b0     <= bus.rxPData;
                     r_haveB0 <= 1'b1;
                  end else begin
                     r_rspData <= {bus.rxPData, r_b0};
                     r_rspVld  <= 1'b1;
                     r_state   <= IDLE;
                  end
               end else if (r_cnt == TO_LAST) begin
                  r_rspTo <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.cmdRdy     = (r_state == IDLE);
   assign bus.busy       = (r_state != IDLE);
   assign bus.txPData    = r_txData;
   assign bus.txDVld     = r_txVld;
   assign bus.rspData    = r_rspData;
   assign bus.rspVld     = r_rspVld;
   assign bus.rspTimeout = r_rspTo;
endmodule

// File: tb/tb_sys_cmd_gen.sv
// Self-checking bench for sys_cmd_gen: directed and random commands compared against
// a frame/response reference model built from byte lists and cycle arithmetic.
module tb_sys_cmd_gen;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  expFrame[$];
   logic [7:0]  gotFrame[$];
   logic [15:0] expRsp = 16'h0000;

   sys_cmd_gen_if bus ();

   sys_cmd_gen #(.TIMEOUT_CYC(TIMEOUT)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired before summary");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_cmdRdy"}, bus.cmdRdy, 1);
      checkOutput({tag, "_txDVld"}, bus.txDVld, 0);
      checkOutput({tag, "_txPData"}, bus.txPData, 0);
      checkOutput({tag, "_rspData"}, bus.rspData, 0);
      checkOutput({tag, "_rspVld"}, bus.rspVld, 0);
      checkOutput({tag, "_rspTimeout"}, bus.rspTimeout, 0);
      checkOutput({tag, "_busy"}, bus.busy, 0);
   endtask

   // Reference frame: the byte list a command must produce on the TX side.
   task automatic buildFrame(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                             input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
      expFrame.delete();
      case (t)
         2'd0: begin
            expFrame.push_back(8'hAA); expFrame.push_back({4'h0, a}); expFrame.push_back(d);
         end
         2'd1: begin
            expFrame.push_back(8'hBB); expFrame.push_back({4'h0, a});
         end
         2'd2: begin
            expFrame.push_back(8'hCC); expFrame.push_back(oa);
            expFrame.push_back(ob);    expFrame.push_back({4'h0, f});
         end
         default: begin
            expFrame.push_back(8'hDD); expFrame.push_back({4'h0, f});
         end
      endcase
   endtask

   // gap0/gap1: cycles after the previous event at which response bytes arrive; 0 = never.
   task automatic applyStimulus(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                                input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                                input bit randRdy, input int gap0, input int gap1,
                                input logic [7:0] r0, input logic [7:0] r1);
      int         cycles;
      bit         stalled;
      logic [7:0] heldByte;
      int         need;
      int         got;
      int         lastEdge;
      bit         done;
      bit         rxNow;
      buildFrame(t, a, d, oa, ob, f);
      checkOutput("cmdRdyIdle", bus.cmdRdy, 1);
      checkOutput("busyIdle", bus.busy, 0);
      bus.cmdVld = 1'b1; bus.cmdType = t; bus.cmdAddr = a; bus.cmdData = d;
      bus.cmdOpa = oa;   bus.cmdOpb = ob; bus.cmdFun = f;
      bus.rxDVld = 1'b0;
      tick();
      bus.cmdVld  = 1'b0;
      bus.cmdType = 2'($urandom); bus.cmdAddr = 4'($urandom); bus.cmdData = 8'($urandom);
      bus.cmdOpa  = 8'($urandom); bus.cmdOpb  = 8'($urandom); bus.cmdFun  = 4'($urandom);
      checkOutput("busyAfterAccept", bus.busy, 1);
      gotFrame.delete();
      cycles = 0; stalled = 0; heldByte = 8'h00;
      while (gotFrame.size() < expFrame.size() && cycles < 400) begin
         bus.txRdy   = randRdy ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.rxDVld  = ($urandom_range(0, 3) == 0);
         bus.rxPData = 8'($urandom);
         checkOutput("txVld", bus.txDVld, 1);
         if (stalled) checkOutput("txHold", bus.txPData, heldByte);
         if (bus.txDVld && bus.txRdy) gotFrame.push_back(bus.txPData);
         stalled  = bus.txDVld && !bus.txRdy;
         heldByte = bus.txPData;
         cycles++;
         tick();
      end
      bus.rxDVld = 1'b0;
      bus.txRdy  = 1'($urandom_range(0, 1));
      checkOutput("frameLen", gotFrame.size(), expFrame.size());
      foreach (expFrame[i])
         if (i < gotFrame.size()) checkOutput($sformatf("frameByte%0d", i), gotFrame[i], expFrame[i]);
      if (!randRdy) checkOutput("frameCycles", cycles, expFrame.size());
      checkOutput("txVldDrop", bus.txDVld, 0);
      if (t == 2'd0) begin
         checkOutput("cmdRdyType0", bus.cmdRdy, 1);
         checkOutput("noRspType0", bus.rspVld, 0);
         return;
      end
      checkOutput("busyWait", bus.busy, 1);
      need = (t == 2'd1) ? 1 : 2;
      got = 0; lastEdge = 0; done = 0;
      for (int k = 1; k <= 200 && !done; k++) begin
         rxNow = (got == 0 && gap0 != 0 && k == lastEdge + gap0) ||
                 (got == 1 && gap1 != 0 && k == lastEdge + gap1);
         bus.rxDVld  = rxNow;
         bus.rxPData = (got == 0) ? r0 : r1;
         tick();
         bus.rxDVld = 1'b0;
         if (rxNow) begin
            got++;
            lastEdge = k;
         end
         if (rxNow && got == need) begin
            expRsp = (need == 1) ? {8'h00, r0} : {r1, r0};
            checkOutput("rspVld", bus.rspVld, 1);
            checkOutput("rspTimeoutQuiet", bus.rspTimeout, 0);
            done = 1;
         end else if (!rxNow && (k - lastEdge) == TIMEOUT) begin
            checkOutput("rspTimeout", bus.rspTimeout, 1);
            checkOutput("rspVldQuiet", bus.rspVld, 0);
            done = 1;
         end else begin
            checkOutput("rspVldEarly", bus.rspVld, 0);
            checkOutput("rspTimeoutEarly", bus.rspTimeout, 0);
         end
      end
      checkOutput("rspBound", done, 1);
      checkOutput("rspData", bus.rspData, expRsp);
      checkOutput("cmdRdyAfterRsp", bus.cmdRdy, 1);
      checkOutput("busyAfterRsp", bus.busy, 0);
      tick();
      checkOutput("rspVldPulse", bus.rspVld, 0);
      checkOutput("rspTimeoutPulse", bus.rspTimeout, 0);
   endtask

   task automatic idleNoise(input int n);
      for (int i = 0; i < n; i++) begin
         bus.rxDVld  = 1'($urandom_range(0, 1));
         bus.rxPData = 8'($urandom);
         tick();
         checkOutput("idleRspVld", bus.rspVld, 0);
         checkOutput("idleRspData", bus.rspData, expRsp);
         checkOutput("idleBusy", bus.busy, 0);
      end
      bus.rxDVld = 1'b0;
   endtask

   initial begin
      int mode;
      int g0;
      int g1;
      bus.cmdVld = 1'b0; bus.cmdType = 2'd0; bus.cmdAddr = 4'h0; bus.cmdData = 8'h00;
      bus.cmdOpa = 8'h00; bus.cmdOpb = 8'h00; bus.cmdFun = 4'h0;
      bus.txRdy = 1'b0; bus.rxPData = 8'h00; bus.rxDVld = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkReset("reset");
      @(negedge clk) rst_n = 1'b1;
      tick();

      applyStimulus(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 0, 0, 8'h00, 8'h00);
      applyStimulus(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 10, 0, 8'h7E, 8'h00);
      applyStimulus(2'd2, 4'h0, 8'h00, 8'h10, 8'h20, 4'h1, 1'b1, 3, 5, 8'h34, 8'h12);
      applyStimulus(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h4, 1'b0, 0, 0, 8'h00, 8'h00);
      applyStimulus(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h4, 1'b0, 10, 0, 8'h99, 8'h00);
      idleNoise(5);
      applyStimulus(2'd2, 4'h0, 8'h00, 8'hA5, 8'h5A, 4'h3, 1'b1, TIMEOUT, TIMEOUT, 8'hC3, 8'h3C);

      bus.cmdVld = 1'b1; bus.cmdType = 2'd2; bus.cmdOpa = 8'h55; bus.cmdOpb = 8'h66; bus.cmdFun = 4'h7;
      tick();
      bus.cmdVld = 1'b0;
      bus.txRdy  = 1'b1;
      tick();
      tick();
      checkOutput("midFrameByte", bus.txPData, 8'h66);
      #2 rst_n = 1'b0;
      #1;
      expRsp = 16'h0000;
      checkReset("midReset");
      @(negedge clk) rst_n = 1'b1;
      tick();
      applyStimulus(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 4, 0, 8'h42, 8'h00);

      for (int n = 0; n < 16; n++) begin
         mode = $urandom_range(0, 3);
         g0 = (mode == 0) ? 0 : $urandom_range(1, TIMEOUT);
         g1 = (mode == 1) ? 0 : $urandom_range(1, TIMEOUT);
         applyStimulus(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       4'($urandom), 1'($urandom_range(0, 1)), g0, g1, 8'($urandom), 8'($urandom));
         if (n % 4 == 3) idleNoise(2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
